// File: rtl/dtw_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : dtw_score_tracker
// Description : Tracks the minimum DTW cost, and the position where it first
//               occurs, over a run of ref_len cost samples coming from the
//               last PE of a systolic DTW array.
// Revision    : 1.0 - initial release
// ============================================================================
module dtw_score_tracker #(
  parameter int width     = 16,
  parameter int idx_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [idx_width-1:0] ref_len,
  input  logic                 in_valid,
  input  logic [width-1:0]     in_cost,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [width-1:0]     min_cost,
  output logic [idx_width-1:0] min_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [idx_width-1:0] IDX_ONE  = {{(idx_width-1){1'b0}}, 1'b1};
  localparam logic [idx_width-1:0] IDX_ZERO = '0;
  localparam logic [width-1:0]     COST_MAX = '1;

  state_t               state_q,     state_d;
  logic [idx_width-1:0] ref_len_q,   ref_len_d;
  logic [idx_width-1:0] cnt_q,       cnt_d;
  logic [width-1:0]     run_min_q,   run_min_d;
  logic [idx_width-1:0] run_idx_q,   run_idx_d;
  logic [width-1:0]     min_cost_q,  min_cost_d;
  logic [idx_width-1:0] min_idx_q,   min_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic [idx_width-1:0] cnt_inc;

  // Next-state and datapath: accept samples in RUN, publish the result in DONE.
  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    cnt_d       = cnt_q;
    run_min_d   = run_min_q;
    run_idx_d   = run_idx_q;
    min_cost_d  = min_cost_q;
    min_idx_d   = min_idx_q;
    out_valid_d = out_valid_q;
    cnt_inc     = cnt_q + IDX_ONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ref_len_d   = ref_len;
          cnt_d       = IDX_ZERO;
          run_min_d   = COST_MAX;
          run_idx_d   = IDX_ZERO;
          out_valid_d = 1'b0;
          // An empty run has nothing to score: go straight to the result.
          state_d     = (ref_len == IDX_ZERO) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          // Strict compare so a tie keeps the earlier position.
          if (in_cost < run_min_q) begin
            run_min_d = in_cost;
            run_idx_d = cnt_q;
          end
          cnt_d = cnt_inc;
          // cnt_q == ref_len-1 written without the subtraction; ref_len >= 1 here.
          if (cnt_inc == ref_len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        min_cost_d  = run_min_q;
        min_idx_d   = run_idx_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake/status outputs are decoded from the next state and registered.
    in_ready_d = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ref_len_q   <= IDX_ZERO;
      cnt_q       <= IDX_ZERO;
      run_min_q   <= COST_MAX;
      run_idx_q   <= IDX_ZERO;
      min_cost_q  <= '0;
      min_idx_q   <= IDX_ZERO;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_len_q   <= ref_len_d;
      cnt_q       <= cnt_d;
      run_min_q   <= run_min_d;
      run_idx_q   <= run_idx_d;
      min_cost_q  <= min_cost_d;
      min_idx_q   <= min_idx_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign min_cost  = min_cost_q;
  assign min_idx   = min_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_dtw_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtw_score_tracker
// Description : Scoreboard bench for dtw_score_tracker with directed and
//               randomized runs checked against a list-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtw_score_tracker;

  localparam int W  = 16;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] ref_len;
  logic          in_valid;
  logic [W-1:0]  in_cost;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [W-1:0]  min_cost;
  logic [IW-1:0] min_idx;

  typedef struct {
    logic [W-1:0]  cost;
    logic [IW-1:0] idx;
  } result_t;

  result_t      sb[$];
  logic [W-1:0] stim[$];
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0]  last_cost = '0;
  logic [IW-1:0] last_idx  = '0;

  dtw_score_tracker #(.width(W), .idx_width(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_len(ref_len),
    .in_valid(in_valid), .in_cost(in_cost), .in_ready(in_ready),
    .busy(busy), .done(done), .out_valid(out_valid),
    .min_cost(min_cost), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: the smallest value in the list and the first place it occurs.
  function automatic result_t model(input int n);
    result_t r;
    logic [W-1:0] m;
    m = '1;
    for (int i = 0; i < n; i++) if (stim[i] < m) m = stim[i];
    r.cost = m;
    r.idx  = '0;
    for (int i = n - 1; i >= 0; i--) if (stim[i] == m) r.idx = i;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest expected result, one cycle later.
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          @(negedge clk);
          chk("out_valid", out_valid, 1);
          chk("min_cost", min_cost, e.cost);
          chk("min_idx", min_idx, e.idx);
        end
      end
    end
  end

  // One scoring run over stim[0..len-1]; abort_after >= 0 resets after that many accepts.
  task automatic run(input int len, input bit gaps, input bit mid_start, input int abort_after);
    int waitc;
    result_t e;
    @(negedge clk);
    start   = 1'b1;
    ref_len = len;
    if (abort_after < 0) sb.push_back(model(len));
    e = model(len);
    @(negedge clk);
    start   = 1'b0;
    ref_len = $urandom;
    chk("start_clears_out_valid", out_valid, 0);
    chk("start_holds_min_cost", min_cost, last_cost);
    chk("start_holds_min_idx", min_idx, last_idx);
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_no_ready", in_ready, 0);
    end else begin
      chk("busy_in_run", busy, 1);
    end
    for (int i = 0; i < len; i++) begin
      waitc = 0;
      while (!in_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        return;
      end
      in_valid = 1'b1;
      in_cost  = stim[i];
      if (mid_start && i == 1) begin
        start   = 1'b1;
        ref_len = 1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      in_cost  = $urandom;
      if (abort_after >= 0 && i + 1 == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_min_cost", min_cost, 0);
        chk("rst_min_idx", min_idx, 0);
        last_cost = '0;
        last_idx  = '0;
        repeat (4) @(negedge clk);
        return;
      end
      chk(i == len - 1 ? "done_after_last" : "no_early_done", done, (i == len - 1) ? 1 : 0);
      if (gaps && i != len - 1) begin
        @(negedge clk);
        chk("gap_no_done", done, 0);
      end
    end
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    last_cost = e.cost;
    last_idx  = e.idx;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ref_len = '0; in_valid = 1'b0; in_cost = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_min_cost", min_cost, 0);
    chk("reset_min_idx", min_idx, 0);
    rst = 1'b0;

    stim = '{16'd9, 16'd3, 16'd7, 16'd5};
    run(4, 1'b0, 1'b0, -1);
    stim = '{16'd4, 16'd2, 16'd2};
    run(3, 1'b1, 1'b0, -1);
    stim = {};
    run(0, 1'b0, 1'b0, -1);
    stim = '{16'd7, 16'd1, 16'd9, 16'd2, 16'd3};
    run(5, 1'b0, 1'b0, 2);
    stim = '{16'd6, 16'd4, 16'd5, 16'd8, 16'd4};
    run(5, 1'b0, 1'b0, -1);
    stim = '{16'd8, 16'd6, 16'd1};
    run(3, 1'b0, 1'b1, -1);
    stim = '{16'hFFFF, 16'hFFFF};
    run(2, 1'b0, 1'b0, -1);

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, 9);
      stim = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       stim.push_back(16'hFFFF);
          1:       stim.push_back(W'($urandom));
          default: stim.push_back(W'($urandom_range(0, 7)));
        endcase
      end
      run(n, 1'($urandom), 1'($urandom), -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
